// File: rtl/interrupt_arbiter.sv
// Interrupt arbiter between the pending register and the multicycle control FSM.
// Masks the 16 pending lines, picks the lowest-index eligible line, runs the
// request/acknowledge handshake, issues the pending-bit clear strobe and blocks
// nesting until the handler returns.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_IDLE    | no request outstanding, arbitrating every cycle
// ST_REQUEST | irq_o high, vector frozen, waiting for ack or withdraw
// ST_SERVICE | handler running, no new request until reti_i
module interrupt_arbiter #(
    parameter logic [15:0] HANDLER_BASE        = 16'h0100,
    parameter int unsigned HANDLER_STRIDE_LOG2 = 4
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [15:0] int_reg_i,
    input  logic        int_enable_i,
    input  logic        int_mask_we_i,
    input  logic [15:0] int_mask_data_i,
    input  logic        irq_ack_i,
    input  logic        reti_i,
    output logic [15:0] int_mask_o,
    output logic        irq_o,
    output logic [3:0]  irq_vector_o,
    output logic [15:0] handler_addr_o,
    output logic        ir_clr_en_o,
    output logic [3:0]  ir_clr_select_o,
    output logic        in_service_o
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQUEST = 2'd1,
        ST_SERVICE = 2'd2
    } state_e;

    state_e      state_q,         state_d;
    logic [15:0] int_mask_q,      int_mask_d;
    logic        irq_q,           irq_d;
    logic [3:0]  irq_vector_q,    irq_vector_d;
    logic        ir_clr_en_q,     ir_clr_en_d;
    logic [3:0]  ir_clr_select_q, ir_clr_select_d;
    logic        in_service_q,    in_service_d;

    logic [15:0] eligible;
    logic [3:0]  winner;
    logic        withdraw;
    logic [15:0] vector_ext;

    // Lowest set index wins; scanning downward lets the last hit be the lowest.
    function automatic logic [3:0] lowest_set(input logic [15:0] v);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (v[i]) idx = i[3:0];
        end
        return idx;
    endfunction

    // Eligibility uses the registered mask, so a mask write only affects the next cycle.
    always_comb begin
        eligible = int_enable_i ? (int_reg_i & int_mask_q) : 16'h0000;
        winner   = lowest_set(eligible);
        withdraw = !int_reg_i[irq_vector_q] || !int_mask_q[irq_vector_q] || !int_enable_i;
    end

    // Next-state and registered-output decode for the handshake FSM.
    always_comb begin
        state_d         = state_q;
        int_mask_d      = int_mask_q;
        irq_d           = irq_q;
        irq_vector_d    = irq_vector_q;
        ir_clr_en_d     = 1'b0;
        ir_clr_select_d = ir_clr_select_q;
        in_service_d    = in_service_q;

        if (int_mask_we_i) begin
            int_mask_d = int_mask_data_i;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (eligible != 16'h0000) begin
                    state_d      = ST_REQUEST;
                    irq_d        = 1'b1;
                    irq_vector_d = winner;
                end
            end
            ST_REQUEST: begin
                // Ack takes precedence over a simultaneous withdraw condition.
                if (irq_ack_i) begin
                    state_d         = ST_SERVICE;
                    irq_d           = 1'b0;
                    ir_clr_en_d     = 1'b1;
                    ir_clr_select_d = irq_vector_q;
                    in_service_d    = 1'b1;
                end else if (withdraw) begin
                    state_d = ST_IDLE;
                    irq_d   = 1'b0;
                end
            end
            ST_SERVICE: begin
                if (reti_i) begin
                    state_d      = ST_IDLE;
                    in_service_d = 1'b0;
                end
            end
            default: begin
                state_d      = ST_IDLE;
                irq_d        = 1'b0;
                in_service_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset clears everything except the upstream pending bits.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q         <= ST_IDLE;
            int_mask_q      <= 16'h0000;
            irq_q           <= 1'b0;
            irq_vector_q    <= 4'd0;
            ir_clr_en_q     <= 1'b0;
            ir_clr_select_q <= 4'd0;
            in_service_q    <= 1'b0;
        end else begin
            state_q         <= state_d;
            int_mask_q      <= int_mask_d;
            irq_q           <= irq_d;
            irq_vector_q    <= irq_vector_d;
            ir_clr_en_q     <= ir_clr_en_d;
            ir_clr_select_q <= ir_clr_select_d;
            in_service_q    <= in_service_d;
        end
    end

    // Handler address is a pure function of the latched vector, wrapping at 16 bits.
    always_comb begin
        vector_ext     = {12'h000, irq_vector_q};
        handler_addr_o = HANDLER_BASE + (vector_ext << HANDLER_STRIDE_LOG2);
    end

    assign int_mask_o      = int_mask_q;
    assign irq_o           = irq_q;
    assign irq_vector_o    = irq_vector_q;
    assign ir_clr_en_o     = ir_clr_en_q;
    assign ir_clr_select_o = ir_clr_select_q;
    assign in_service_o    = in_service_q;

endmodule

// File: tb/tb_interrupt_arbiter.sv
// Bench for interrupt_arbiter: directed scenarios followed by random traffic,
// every cycle compared against a behavioural model of the handshake.
module tb_interrupt_arbiter;

    logic        clk;
    logic        rst_n;
    logic [15:0] int_reg;
    logic        int_en;
    logic        mask_we;
    logic [15:0] mask_data;
    logic        ack;
    logic        reti;
    logic [15:0] int_mask;
    logic        irq;
    logic [3:0]  irq_vector;
    logic [15:0] handler_addr;
    logic        clr_en;
    logic [3:0]  clr_sel;
    logic        in_service;

    int n_total = 0;
    int n_bad   = 0;

    // model: outstanding request flag, handler-running flag, and the visible values
    bit          m_req;
    bit          m_serv;
    int          m_vec;
    logic [15:0] m_mask;
    bit          m_clr_en;
    int          m_clr_sel;

    interrupt_arbiter dut (
        .clk_i           (clk),
        .rst_n_i         (rst_n),
        .int_reg_i       (int_reg),
        .int_enable_i    (int_en),
        .int_mask_we_i   (mask_we),
        .int_mask_data_i (mask_data),
        .irq_ack_i       (ack),
        .reti_i          (reti),
        .int_mask_o      (int_mask),
        .irq_o           (irq),
        .irq_vector_o    (irq_vector),
        .handler_addr_o  (handler_addr),
        .ir_clr_en_o     (clr_en),
        .ir_clr_select_o (clr_sel),
        .in_service_o    (in_service)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_req     = 0;
        m_serv    = 0;
        m_vec     = 0;
        m_mask    = 16'h0000;
        m_clr_en  = 0;
        m_clr_sel = 0;
    endtask

    task automatic check_all();
        check("irq",        {31'd0, irq},        {31'd0, m_req});
        check("vector",     {28'd0, irq_vector}, m_vec);
        check("handler",    {16'd0, handler_addr}, (32'h0100 + m_vec * 16) & 32'hFFFF);
        check("clr_en",     {31'd0, clr_en},     {31'd0, m_clr_en});
        check("clr_sel",    {28'd0, clr_sel},    m_clr_sel);
        check("in_service", {31'd0, in_service}, {31'd0, m_serv});
        check("mask",       {16'd0, int_mask},   {16'd0, m_mask});
    endtask

    // One clock: model consumes the inputs present at the edge, then outputs are compared.
    task automatic step();
        logic [15:0] elig;
        logic [15:0] old_mask;
        @(posedge clk);
        old_mask = m_mask;
        elig     = int_en ? (int_reg & old_mask) : 16'h0000;
        m_clr_en = 0;
        if (mask_we) m_mask = mask_data;
        if (m_serv) begin
            if (reti) m_serv = 0;
        end else if (m_req) begin
            if (ack) begin
                m_req     = 0;
                m_serv    = 1;
                m_clr_en  = 1;
                m_clr_sel = m_vec;
            end else if (!int_reg[m_vec] || !old_mask[m_vec] || !int_en) begin
                m_req = 0;
            end
        end else if (elig != 0) begin
            for (int i = 0; i < 16; i++) begin
                if (elig[i]) begin
                    m_vec = i;
                    break;
                end
            end
            m_req = 1;
        end
        #1;
        check_all();
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic write_mask(input logic [15:0] v);
        mask_we   = 1'b1;
        mask_data = v;
        step();
        mask_we   = 1'b0;
    endtask

    // Drain a pending request back to idle: ack, drop pending bits, return.
    task automatic finish_handler();
        ack = 1'b1;
        step();
        ack     = 1'b0;
        int_reg = 16'h0000;
        reti    = 1'b1;
        step();
        reti = 1'b0;
        step();
    endtask

    initial begin
        rst_n     = 1'b0;
        int_reg   = 16'h0000;
        int_en    = 1'b0;
        mask_we   = 1'b0;
        mask_data = 16'h0000;
        ack       = 1'b0;
        reti      = 1'b0;
        model_reset();
        #3;
        check_all();
        #9 rst_n = 1'b1;

        // 1: nothing pending, nothing happens
        write_mask(16'hFFFF);
        int_en = 1'b1;
        steps(10);
        check("idle_irq", {31'd0, irq}, 32'd0);

        // 2: two lines pending, lowest wins, handler address and clear strobe
        int_reg = 16'h0028;
        step();
        check("t2_irq", {31'd0, irq}, 32'd1);
        check("t2_vec", {28'd0, irq_vector}, 32'd3);
        check("t2_addr", {16'd0, handler_addr}, 32'h0130);
        ack = 1'b1;
        step();
        ack = 1'b0;
        check("t2_clr_en", {31'd0, clr_en}, 32'd1);
        check("t2_clr_sel", {28'd0, clr_sel}, 32'd3);
        check("t2_in_service", {31'd0, in_service}, 32'd1);
        int_reg = 16'h0020;
        step();
        check("t2_clr_once", {31'd0, clr_en}, 32'd0);
        reti = 1'b1;
        step();
        reti = 1'b0;

        // 3: higher-priority arrival during REQUEST waits its turn
        step();
        check("t3_vec5", {28'd0, irq_vector}, 32'd5);
        int_reg = 16'h0022;
        steps(3);
        check("t3_hold5", {28'd0, irq_vector}, 32'd5);
        ack = 1'b1;
        step();
        ack     = 1'b0;
        int_reg = 16'h0002;
        reti    = 1'b1;
        step();
        reti = 1'b0;
        step();
        check("t3_vec1", {28'd0, irq_vector}, 32'd1);
        check("t3_irq1", {31'd0, irq}, 32'd1);
        finish_handler();

        // 4: masked line released by a mask write, arbitrated the cycle after
        write_mask(16'hFFF7);
        int_reg = 16'h0008;
        steps(3);
        check("t4_masked", {31'd0, irq}, 32'd0);
        write_mask(16'hFFFF);
        check("t4_edge_w", {31'd0, irq}, 32'd0);
        step();
        check("t4_edge_w1", {31'd0, irq}, 32'd1);
        finish_handler();

        // 5: withdraw when the pending bit drops, and ack winning over withdraw
        int_reg = 16'h0004;
        step();
        check("t5_vec2", {28'd0, irq_vector}, 32'd2);
        int_reg = 16'h0000;
        step();
        check("t5_withdraw", {31'd0, irq}, 32'd0);
        check("t5_no_serv", {31'd0, in_service}, 32'd0);
        int_reg = 16'h0004;
        step();
        int_reg = 16'h0000;
        ack     = 1'b1;
        step();
        ack = 1'b0;
        check("t5_ack_wins", {31'd0, in_service}, 32'd1);
        check("t5_ack_clr", {31'd0, clr_en}, 32'd1);
        reti = 1'b1;
        step();
        reti = 1'b0;

        // 6: asynchronous reset in SERVICE, then silence until the mask is rewritten
        int_reg = 16'h0010;
        step();
        ack = 1'b1;
        step();
        ack = 1'b0;
        check("t6_serv", {31'd0, in_service}, 32'd1);
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        check("t6_rst_serv", {31'd0, in_service}, 32'd0);
        check("t6_rst_mask", {16'd0, int_mask}, 32'd0);
        check_all();
        #2 rst_n = 1'b1;
        int_reg = 16'hFFFF;
        steps(5);
        check("t6_no_irq", {31'd0, irq}, 32'd0);
        write_mask(16'hFFFF);
        step();
        check("t6_irq_back", {31'd0, irq}, 32'd1);
        finish_handler();

        // random traffic against the model
        for (int c = 0; c < 600; c++) begin
            int_reg   = 16'(1 << $urandom_range(0, 15)) | (($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'h0000);
            if ($urandom_range(0, 4) == 0) int_reg = 16'h0000;
            int_en    = ($urandom_range(0, 9) != 0);
            mask_we   = ($urandom_range(0, 9) == 0);
            mask_data = ($urandom_range(0, 1) == 0) ? 16'hFFFF : 16'($urandom);
            ack       = ($urandom_range(0, 2) == 0);
            reti      = ($urandom_range(0, 3) == 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
